// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// source tags, the fetch funct3 code and the in-flight tag record.
package riscv_mem_pkg;

    localparam logic       SRC_IF            = 1'b0;
    localparam logic       SRC_DM            = 1'b1;
    localparam logic [2:0] FUNCT3_LW         = 3'b010;
    localparam int         DEFAULT_DATA_BASE = 48;

    typedef struct packed {
        logic valid;
        logic src;
        logic killed;
    } tag_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of in-flight read tags; the tail entry lines up
// with the memory read data returning this cycle.
module mem_tag_pipe
    import riscv_mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    input  logic push_src,
    input  logic kill_if,
    output logic out_valid,
    output logic out_src,
    output logic out_killed
);

    tag_t stage_q [LAT];
    tag_t stage_d [LAT];

    // Next stage contents: new entry at the head, kill marks applied as entries advance
    always_comb begin
        stage_d[0].valid  = push_valid;
        stage_d[0].src    = push_src;
        stage_d[0].killed = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
            if (kill_if && (stage_q[i-1].src == SRC_IF)) begin
                stage_d[i].killed = 1'b1;
            end else begin
                stage_d[i].killed = stage_q[i-1].killed;
            end
        end
    end

    // Tag storage with synchronous clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid  = stage_q[LAT-1].valid;
    assign out_src    = stage_q[LAT-1].src;
    assign out_killed = stage_q[LAT-1].killed;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Per-cycle arbiter sharing one memory port between instruction fetch and
// load/store, with bounded fetch starvation and in-order response steering.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MEM_LAT    = 1,
    parameter int DATA_BASE  = DEFAULT_DATA_BASE,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [2:0]      dm_func,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [2:0]      mem_func,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [SW-1:0]   starve_q, starve_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            force_if_s;
    logic            tail_valid_s, tail_src_s, tail_killed_s;

    // Grant selection: data wins unless fetch has waited STARVE_MAX cycles
    always_comb begin
        force_if_s = if_req && (starve_q == STARVE_TOP);
        dm_gnt     = 1'b0;
        if_gnt     = 1'b0;
        starve_d   = '0;
        if (!rst) begin
            dm_gnt = dm_req && !force_if_s;
            if_gnt = if_req && !dm_gnt;
            if (if_req && !if_gnt) begin
                starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end else begin
            starve_d = '0;
        end
    end

    // Memory command mux; idle cycles drive zeros so mem_we never glitches
    always_comb begin
        mem_req   = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_func  = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_func  = dm_func;
            mem_addr  = dm_addr + XLEN'(DATA_BASE);
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_func  = FUNCT3_LW;
            mem_addr  = if_addr;
        end else begin
            mem_we    = 1'b0;
        end
    end

    mem_tag_pipe #(
        .LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (if_gnt | (dm_gnt & ~dm_we)),
        .push_src   (dm_gnt ? SRC_DM : SRC_IF),
        .kill_if    (if_flush),
        .out_valid  (tail_valid_s),
        .out_src    (tail_src_s),
        .out_killed (tail_killed_s)
    );

    // Response steering; a flush also suppresses a fetch returning this cycle
    always_comb begin
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        if_rdata_d = '0;
        dm_rdata_d = '0;
        if (!rst) begin
            if_rvalid  = tail_valid_s && (tail_src_s == SRC_IF) && !tail_killed_s && !if_flush;
            dm_rvalid  = tail_valid_s && (tail_src_s == SRC_DM);
            if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
            dm_rdata_d = dm_rvalid ? mem_rdata : dm_rdata_q;
        end else begin
            if_rvalid  = 1'b0;
            dm_rvalid  = 1'b0;
        end
    end

    assign if_rdata = if_rdata_d;
    assign dm_rdata = dm_rdata_d;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule
